// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// master drives requests; slave (the arbiter) returns the registered grant.
interface rr_arbiter_4_if #(
  parameter int N = 4
) ();
  localparam int IW = $clog2(N);

  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic          valid;
  logic [IW-1:0] gnt_id;

  modport master (output req, input gnt, input valid, input gnt_id);
  modport slave  (input req, output gnt, output valid, output gnt_id);
endinterface

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter with registered one-hot grant, grant hold while the
// owner keeps requesting, and a bounded hold length of MAX_HOLD cycles.
module rr_arbiter_4 #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 4
) (
  input logic           clk,
  input logic           rst,
  rr_arbiter_4_if.slave arb
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_HOLD);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          valid_q, valid_d;
  logic [IW-1:0] gnt_id_q, gnt_id_d;

  logic [IW-1:0] next_owner_s;
  logic [IW-1:0] start_s;
  logic [IW:0]   search_s;
  logic          hit_s;
  logic [IW-1:0] win_s;

  // First set bit of r scanning start, start+1, ... with wrap; MSB is the hit flag.
  // Scanning backwards lets the earliest position in the order overwrite later ones.
  function automatic logic [IW:0] search_f(input logic [N-1:0] r, input logic [IW-1:0] start);
    logic [IW:0]   res;
    logic [IW-1:0] pos;
    res = {(IW + 1){1'b0}};
    for (int k = N - 1; k >= 0; k--) begin
      pos = IW'((int'(start) + k) % N);
      if (r[pos]) begin
        res = {1'b1, pos};
      end
    end
    return res;
  endfunction

  function automatic logic [N-1:0] onehot_f(input logic [IW-1:0] idx);
    logic [N-1:0] v;
    v      = {N{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  // Next-state: hold, hand over to the next requester in wrap order, or go idle.
  always_comb begin
    next_owner_s = (owner_q == LAST_IDX) ? {IW{1'b0}} : owner_q + IW'(1);
    start_s      = (state_q == BUSY) ? next_owner_s : ptr_q;
    search_s     = search_f(arb.req, start_s);
    hit_s        = search_s[IW];
    win_s        = search_s[IW-1:0];

    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    gnt_d    = gnt_q;
    valid_d  = valid_q;
    gnt_id_d = gnt_id_q;

    case (state_q)
      IDLE: begin
        if (hit_s) begin
          state_d  = BUSY;
          owner_d  = win_s;
          cnt_d    = CW'(1);
          gnt_d    = onehot_f(win_s);
          valid_d  = 1'b1;
          gnt_id_d = win_s;
        end else begin
          state_d  = IDLE;
          cnt_d    = {CW{1'b0}};
          gnt_d    = {N{1'b0}};
          valid_d  = 1'b0;
          gnt_id_d = {IW{1'b0}};
        end
      end
      BUSY: begin
        if (arb.req[owner_q] && (cnt_q < MAX_CNT)) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          ptr_d = next_owner_s;
          if (hit_s) begin
            owner_d  = win_s;
            cnt_d    = CW'(1);
            gnt_d    = onehot_f(win_s);
            valid_d  = 1'b1;
            gnt_id_d = win_s;
          end else begin
            state_d  = IDLE;
            cnt_d    = {CW{1'b0}};
            gnt_d    = {N{1'b0}};
            valid_d  = 1'b0;
            gnt_id_d = {IW{1'b0}};
          end
        end
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = {CW{1'b0}};
        gnt_d    = {N{1'b0}};
        valid_d  = 1'b0;
        gnt_id_d = {IW{1'b0}};
      end
    endcase
  end

  // State and output registers; reset clears outputs without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= {IW{1'b0}};
      cnt_q    <= {CW{1'b0}};
      owner_q  <= {IW{1'b0}};
      gnt_q    <= {N{1'b0}};
      valid_q  <= 1'b0;
      gnt_id_q <= {IW{1'b0}};
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      gnt_q    <= gnt_d;
      valid_q  <= valid_d;
      gnt_id_q <= gnt_id_d;
    end
  end

  assign arb.gnt    = gnt_q;
  assign arb.valid  = valid_q;
  assign arb.gnt_id = gnt_id_q;
endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: directed vector table on MAX_HOLD=4 plus a random
// sweep of MAX_HOLD=4/1/3 instances against a behavioural round-robin model.
module tb_rr_arbiter_4;
  localparam int N    = 4;
  localparam int NDUT = 3;

  typedef struct packed {
    logic       do_rst;
    logic [3:0] req;
    logic [3:0] gnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;

  always #5 clk = ~clk;

  rr_arbiter_4_if #(.N(N)) if4 ();
  rr_arbiter_4_if #(.N(N)) if1 ();
  rr_arbiter_4_if #(.N(N)) if3 ();

  assign if4.req = req;
  assign if1.req = req;
  assign if3.req = req;

  rr_arbiter_4 #(.N(N), .MAX_HOLD(4)) dut4 (.clk(clk), .rst(rst), .arb(if4));
  rr_arbiter_4 #(.N(N), .MAX_HOLD(1)) dut1 (.clk(clk), .rst(rst), .arb(if1));
  rr_arbiter_4 #(.N(N), .MAX_HOLD(3)) dut3 (.clk(clk), .rst(rst), .arb(if3));

  logic [3:0] gnt_s   [NDUT];
  logic       valid_s [NDUT];
  logic [1:0] id_s    [NDUT];

  assign gnt_s[0] = if4.gnt;  assign valid_s[0] = if4.valid;  assign id_s[0] = if4.gnt_id;
  assign gnt_s[1] = if1.gnt;  assign valid_s[1] = if1.valid;  assign id_s[1] = if1.gnt_id;
  assign gnt_s[2] = if3.gnt;  assign valid_s[2] = if3.valid;  assign id_s[2] = if3.gnt_id;

  int n_checks = 0;
  int n_errors = 0;

  vec_t tbl[$];

  int m_owner [NDUT];
  int m_held  [NDUT];
  int m_ptr   [NDUT];
  int m_wait  [NDUT][N];

  function automatic int hold_of(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 1 : 3);
  endfunction

  function automatic int idx_of(input logic [3:0] g);
    for (int i = 0; i < N; i++) begin
      if (g[i]) return i;
    end
    return 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] q, input logic [3:0] g, input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.do_rst = r && (i == 0);
      v.req    = q;
      v.gnt    = g;
      tbl.push_back(v);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++) begin
      m_owner[d] = -1;
      m_held[d]  = 0;
      m_ptr[d]   = 0;
      for (int i = 0; i < N; i++) m_wait[d][i] = 0;
    end
  endtask

  // Owner keeps the grant while requesting and under its hold limit; otherwise
  // the first requester in the rotated priority order takes over.
  task automatic model_step(input int d, input logic [3:0] r);
    int o;
    int pick;
    int c;
    o = m_owner[d];
    if (o >= 0 && r[o] && m_held[d] < hold_of(d)) begin
      m_held[d]++;
    end else begin
      if (o >= 0) m_ptr[d] = (o + 1) % N;
      pick = -1;
      for (int k = 0; k < N; k++) begin
        c = (m_ptr[d] + k) % N;
        if (pick < 0 && r[c]) pick = c;
      end
      m_owner[d] = pick;
      m_held[d]  = (pick >= 0) ? 1 : 0;
    end
  endtask

  function automatic logic [3:0] model_gnt(input int d);
    logic [3:0] g;
    g = 4'b0000;
    if (m_owner[d] >= 0) g[m_owner[d]] = 1'b1;
    return g;
  endfunction

  initial begin
    logic [3:0] g;
    rst = 1'b1;
    req = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", gnt_s[0], 4'b0000);
    check("rst_valid", valid_s[0], 1'b0);
    check("rst_id", id_s[0], 2'd0);
    #2 rst = 1'b0;

    // Reset asserted mid-grant must clear outputs before the next clock edge.
    req = 4'b1111;
    @(posedge clk); #1;
    check("pre_rst_gnt", gnt_s[0], 4'b0001);
    check("pre_rst_valid", valid_s[0], 1'b1);
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    check("async_gnt", gnt_s[0], 4'b0000);
    check("async_valid", valid_s[0], 1'b0);
    check("async_id", id_s[0], 2'd0);
    check("async_gnt_h1", gnt_s[1], 4'b0000);
    req = 4'b0000;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("idle%0d_gnt", i), gnt_s[0], 4'b0000);
      check($sformatf("idle%0d_valid", i), valid_s[0], 1'b0);
    end

    add(1'b1, 4'b1111, 4'b0001, 4);
    add(1'b0, 4'b1111, 4'b0010, 4);
    add(1'b0, 4'b1111, 4'b0100, 4);
    add(1'b0, 4'b1111, 4'b1000, 4);
    add(1'b0, 4'b1111, 4'b0001, 4);
    add(1'b1, 4'b0011, 4'b0001, 2);
    add(1'b0, 4'b0010, 4'b0010, 2);
    add(1'b0, 4'b0000, 4'b0000, 3);
    // ptr is 2 after bit 1 released: scan order 2,3,0,1
    add(1'b0, 4'b0011, 4'b0001, 1);
    add(1'b1, 4'b0100, 4'b0100, 10);
    add(1'b1, 4'b0001, 4'b0001, 2);
    add(1'b0, 4'b1000, 4'b1000, 1);

    foreach (tbl[i]) begin
      if (tbl[i].do_rst) do_reset();
      req = tbl[i].req;
      @(posedge clk); #1;
      check($sformatf("tbl%0d_gnt", i), gnt_s[0], tbl[i].gnt);
      check($sformatf("tbl%0d_valid", i), valid_s[0], |tbl[i].gnt);
      check($sformatf("tbl%0d_id", i), id_s[0], idx_of(tbl[i].gnt));
    end

    do_reset();
    model_reset();
    req = 4'b0000;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 39) == 0) begin
        req = 4'b0000;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (req[i]) req[i] = ($urandom_range(0, 7) != 0);
          else        req[i] = ($urandom_range(0, 2) == 0);
        end
      end
      @(posedge clk); #1;
      for (int d = 0; d < NDUT; d++) begin
        model_step(d, req);
        g = gnt_s[d];
        check($sformatf("rnd_d%0d_gnt", d), g, model_gnt(d));
        check($sformatf("rnd_d%0d_onehot", d), $onehot0(g), 1'b1);
        check($sformatf("rnd_d%0d_valid", d), valid_s[d], |g);
        check($sformatf("rnd_d%0d_id", d), id_s[d], idx_of(g));
        check($sformatf("rnd_d%0d_gnt_req", d), g & ~req, 4'b0000);
        for (int i = 0; i < N; i++) begin
          if (req[i] && !g[i]) m_wait[d][i]++;
          else                 m_wait[d][i] = 0;
          check($sformatf("rnd_d%0d_wait%0d", d, i),
                m_wait[d][i] > (N - 1) * hold_of(d), 1'b0);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
